// File: rtl/threshold_compress_ctrl_if.sv
// Stream bundle for threshold_compress_ctrl: preactivation input and
// compressed-word output, both valid/ready. Names are from the controller side.
interface threshold_compress_ctrl_if #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int N_THR        = 16
);
    localparam int CW = $clog2(N_THR);

    logic                    act_valid_i;
    logic                    act_ready_o;
    logic [31:0]             act_data_i;
    logic [CW-1:0]           act_ch_i;

    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [OUTPUT_WIDTH-1:0] out_data_o;
    logic                    out_last_o;

    modport master (
        output act_valid_i, act_data_i, act_ch_i, out_ready_i,
        input  act_ready_o, out_valid_o, out_data_o, out_last_o
    );

    modport slave (
        input  act_valid_i, act_data_i, act_ch_i, out_ready_i,
        output act_ready_o, out_valid_o, out_data_o, out_last_o
    );
endinterface

// File: rtl/threshold_compress_ctrl.sv
// Sequencer feeding the threshold_compress datapath one trit per cycle.
// THRESHOLD_COMPRESS_CTRL_PERF_EN adds the input stall counter on stall_cnt_o.
module threshold_compress_ctrl #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int N_THR        = 16,
    localparam int CW          = $clog2(N_THR)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_we_i,
    input  logic [CW-1:0]           cfg_addr_i,
    input  logic [31:0]             cfg_thr_i,
    input  logic                    start_i,
    input  logic [15:0]             num_acts_i,
    threshold_compress_ctrl_if.slave bus,
    output logic                    dp_rst_no,
    output logic                    dp_enable_o,
    output logic [31:0]             dp_data_o,
    output logic [31:0]             dp_thresholds_o,
    input  logic [OUTPUT_WIDTH-1:0] dp_data_i,
    input  logic                    dp_full_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [31:0]             stall_cnt_o
);
    localparam int TRITS = OUTPUT_WIDTH * 5 / 8;
    localparam int TW    = (TRITS > 1) ? $clog2(TRITS) : 1;
    localparam logic [31:0] PAD_THR = {16'h0001, 16'hFFFF};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAD,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [15:0]             rem_q, rem_d;
    logic [TW-1:0]           trit_cnt_q, trit_cnt_d;
    logic [31:0]             thr_q [N_THR];
    logic [31:0]             thr_d [N_THR];
    logic                    out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    logic          last_trit;
    logic          stall;
    logic          accept;
    logic          act_ready;
    logic [TW-1:0] trit_nxt;

    // Holding the last trit of a word keeps the buffer free for its capture.
    assign last_trit = (trit_cnt_q == TW'(TRITS - 1));
    assign stall     = last_trit && out_valid_q && !bus.out_ready_i;
    assign accept    = (state_q == S_RUN) && bus.act_valid_i && !stall;
    assign trit_nxt  = last_trit ? '0 : trit_cnt_q + 1'b1;

    always_comb begin
        thr_d = thr_q;
        if (cfg_we_i) begin
            thr_d[cfg_addr_i] = cfg_thr_i;
        end
    end

    always_comb begin
        state_d         = state_q;
        rem_d           = rem_q;
        trit_cnt_d      = trit_cnt_q;
        act_ready       = 1'b0;
        dp_rst_no       = 1'b1;
        dp_enable_o     = 1'b0;
        dp_data_o       = '0;
        dp_thresholds_o = '0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                dp_rst_no = 1'b0;
                if (start_i) begin
                    rem_d      = num_acts_i;
                    trit_cnt_d = '0;
                    state_d    = (num_acts_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy_o    = 1'b1;
                act_ready = !stall;
                if (accept) begin
                    dp_enable_o     = 1'b1;
                    dp_data_o       = bus.act_data_i;
                    dp_thresholds_o = thr_q[bus.act_ch_i];
                    rem_d           = rem_q - 1'b1;
                    trit_cnt_d      = trit_nxt;
                    if (rem_q == 16'd1) begin
                        state_d = last_trit ? S_DRAIN : S_PAD;
                    end
                end
            end
            S_PAD: begin
                busy_o = 1'b1;
                if (!stall) begin
                    dp_enable_o     = 1'b1;
                    dp_thresholds_o = PAD_THR;
                    trit_cnt_d      = trit_nxt;
                    if (last_trit) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (out_valid_q && bus.out_ready_i && out_last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                dp_rst_no = 1'b0;
                done_o    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The final word is the only one whose capture lands in DRAIN.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (out_valid_q && bus.out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (dp_full_i) begin
            out_valid_d = 1'b1;
            out_data_d  = dp_data_i;
            out_last_d  = (state_q == S_DRAIN);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            trit_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < N_THR; i++) begin
                thr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            trit_cnt_q  <= trit_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            thr_q       <= thr_d;
        end
    end

    assign bus.act_ready_o = act_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_last_o  = out_last_q;

`ifdef THRESHOLD_COMPRESS_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start_i) begin
            stall_cnt_d = '0;
        end else if (state_q == S_RUN && bus.act_valid_i && !act_ready
                     && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: doc/threshold_compress_ctrl.md
# threshold_compress_ctrl

Sequencer for the `threshold_compress` ternarization datapath. It holds a small per-channel threshold table, takes a job of N preactivations over a valid/ready stream, and drives the datapath one trit per cycle with the matching thresholds. When a job ends mid-word it pads with zero-trits so the last word completes. Each compressed word goes out on a one-entry valid/ready output buffer; the block sits between the activation producer and the output writer.

## Interface
- `OUTPUT_WIDTH`, 8: compressed word width. `TRITS = OUTPUT_WIDTH*5/8` (5 at default) is derived.
- `N_THR`, 16: threshold table entries. Must be a power of 2. `CW = $clog2(N_THR)`.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cfg_we_i`  in  1  threshold table write strobe.
- `cfg_addr_i`  in  CW  write address.
- `cfg_thr_i`  in  32  thresholds packed as {hi[31:16], lo[15:0]}, signed.
- `start_i`  in  1  job start; sampled only in IDLE.
- `num_acts_i`  in  16  job length in preactivations; sampled with `start_i`.
- `act_valid_i` / `act_ready_o`  in/out  1  preactivation handshake.
- `act_data_i`  in  32  preactivation.
- `act_ch_i`  in  CW  threshold table index for this preactivation.
- `dp_rst_no`  out  1  datapath reset, active-low.
- `dp_enable_o`  out  1  datapath enable; one trit consumed per cycle it is high.
- `dp_data_o`  out  32  preactivation to the datapath.
- `dp_thresholds_o`  out  32  thresholds to the datapath.
- `dp_data_i`  in  OUTPUT_WIDTH  compressed word from the datapath.
- `dp_full_i`  in  1  high for exactly one cycle when `dp_data_i` holds a complete word.
- `out_valid_o` / `out_ready_i`  out/in  1  output handshake.
- `out_data_o`  out  OUTPUT_WIDTH  compressed word.
- `out_last_o`  out  1  marks the final word of the job.
- `busy_o`  out  1  high in RUN, PAD and DRAIN.
- `done_o`  out  1  one-cycle pulse at job end.
- `stall_cnt_o`  out  32  performance counter (see Configuration).

## Operation
- **FSM states:** IDLE, RUN, PAD, DRAIN, DONE.
- **IDLE:**
  - `start_i` with `num_acts_i != 0` → RUN. Load `rem = num_acts_i` and clear `trit_cnt`.
  - `start_i` with `num_acts_i == 0` → DONE. No words are emitted.
- **RUN:**
  - An accept is `act_valid_i && act_ready_o`. On an accept: `dp_enable_o = 1`, `dp_data_o = act_data_i`, `dp_thresholds_o = thr[act_ch_i]` (combinational read), `rem--`, and `trit_cnt` increments, wrapping `TRITS-1 → 0`.
  - On the accept that takes `rem` to 0: if `trit_cnt` wraps to 0, go to DRAIN; otherwise go to PAD.
- **PAD:**
  - Issue one pad trit per cycle until the word completes: `dp_enable_o = 1`, `dp_data_o = 0`, `dp_thresholds_o = {16'h0001, 16'hFFFF}` (yields trit 0).
  - On the last pad trit → DRAIN.
  - PAD obeys the same stall rule as RUN.
- **Capture:** whenever `dp_full_i` is high, load `dp_data_i` into the output buffer and set `out_valid_o`. `out_last_o = 1` if this is the job's final word.
- **Stall rule:** `act_ready_o` and pad issue are suppressed when `trit_cnt == TRITS-1 && out_valid_o && !out_ready_i`. The buffer therefore always has room when the next word arrives.
- **DRAIN:** wait for the final word to be captured and handshaken out → DONE.
- **DONE:** `done_o = 1` for one cycle → IDLE.
- `dp_rst_no = 0` in IDLE and DONE, 1 otherwise. This clears the datapath between jobs.
- `start_i` outside IDLE is ignored.
- Config writes are allowed in any state. A write is visible on the next cycle; a same-cycle read of the written address returns the old value.

## Timing
- **Reset values:**
  - `act_ready_o`, `dp_enable_o`, `dp_rst_no`, `out_valid_o`, `out_last_o`, `busy_o`, `done_o`: 0.
  - Data outputs and `stall_cnt_o`: 0.
  - Threshold table: all 0.
- `rst_i` mid-job aborts immediately: state returns to IDLE and the buffered word is dropped.
- **Latency:**
  - Start → first `act_ready_o`: 1 cycle.
  - Last trit of a word issued in cycle t → `dp_full_i` and capture at t+1 → `out_valid_o` at t+2.
- Throughput is 1 trit/cycle with no stall.
- `done_o` asserts in the cycle after the final output handshake.
- `out_data_o` / `out_last_o` hold stable while `out_valid_o && !out_ready_i`.

## Configuration
- **Macro:** `THRESHOLD_COMPRESS_CTRL_PERF_EN`.
- **Defined:** `stall_cnt_o` counts cycles in RUN with `act_valid_i && !act_ready_o`. It is cleared on an accepted start and saturates at 2^32-1.
- **Undefined:** `stall_cnt_o` is tied to 0 and no counter logic is synthesized.

## Test plan
- **Basic job:** write `thr[3] = {16'd100, -16'd100}`, start `num_acts = 10`, stream 10 acts on ch 3 with no backpressure. Expect exactly 2 words, `out_last_o` on the 2nd, `done_o` one cycle after the 2nd handshake.
- **Padding:** `num_acts = 7`. Expect 3 PAD cycles with pad thresholds on `dp_thresholds_o`, 2 words total, `busy_o` deasserted with `done_o`.
- **Backpressure:** hold `out_ready_i = 0` for 20 cycles after the first word. Expect `act_ready_o = 0` at `trit_cnt == 4`, no word lost, and `stall_cnt_o` equal to the stalled-valid cycles when PERF_EN is defined (0 otherwise).
- **Zero-length job:** `start_i` with `num_acts = 0`. Expect `done_o` 1 cycle after start, and no `dp_enable_o` or `out_valid_o`.
- **Config hazard:** write ch 5 in the same cycle as an accept on ch 5. Expect the old thresholds on `dp_thresholds_o`; the next accept uses the new ones.
- **Reset mid-job:** assert `rst_i` during RUN after 3 acts. Expect all outputs at reset values, and a new 5-act job producing a correct single word.
